// File: rtl/aes_job_master.sv
// -----------------------------------------------------------------------------
// aes_job_master
//
// Register-bus initiator for one AES-192 peripheral. It accepts a job (key
// select, state, plaintext), programs the peripheral's word-indexed register
// map, pulses start, polls ct_valid, and reads back the ciphertext. The result
// is returned on a valid/ready port. The design makes one bus access per
// FSM state-cycle.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   job_valid_i/ready_o    job handshake
//   job_key_sel_i          key slot (0/1/2, 3 aliases 2)
//   job_state_i            AES state word
//   job_pt_i               plaintext
//   res_valid_o/ready_i    result handshake
//   res_ct_o               ciphertext
//   res_err_o              poll timeout (res_ct_o is 0)
//   busy_o                 FSM not idle
//   bus_en_o, bus_we_o     access strobe, write enable
//   bus_addr_o             access address
//   bus_wdata_o            write data
//   bus_rdata_i            read data, combinational in the strobe cycle
// -----------------------------------------------------------------------------
module aes_job_master #(
    parameter int unsigned               AXI_ADDR_WIDTH = 64,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned               POLL_TIMEOUT   = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      job_valid_i,
    output logic                      job_ready_o,
    input  logic [1:0]                job_key_sel_i,
    input  logic [127:0]              job_state_i,
    input  logic [127:0]              job_pt_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [127:0]              res_ct_o,
    output logic                      res_err_o,
    output logic                      busy_o,
    output logic                      bus_en_o,
    output logic                      bus_we_o,
    output logic [AXI_ADDR_WIDTH-1:0] bus_addr_o,
    output logic [63:0]               bus_wdata_o,
    input  logic [63:0]               bus_rdata_i
);

    localparam int unsigned    PCW       = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_TIMEOUT - 1);

    localparam logic [5:0] IDX_START = 6'd0;
    localparam logic [5:0] IDX_PC    = 6'd1;
    localparam logic [5:0] IDX_CTV   = 6'd11;
    localparam logic [5:0] IDX_CT    = 6'd12;
    localparam logic [5:0] IDX_STATE = 6'd16;
    localparam logic [5:0] IDX_KSEL  = 6'd32;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_KSEL, S_WR_STATE, S_WR_PT, S_START_HI,
        S_START_LO, S_POLL, S_RD_CT, S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     k_q, k_d;
    logic [PCW-1:0] poll_q, poll_d;
    logic [127:0]   st_q, pt_q, ct_q, ct_d;
    logic           err_q, err_d;

    logic                      en_d, we_d;
    logic [5:0]                idx_d;
    logic [31:0]               data_d;
    logic                      bus_en_q, bus_we_q;
    logic [AXI_ADDR_WIDTH-1:0] bus_addr_q;
    logic [31:0]               bus_wdata_q;

    logic unused_rdata;
    assign unused_rdata = ^bus_rdata_i[63:32];

    function automatic logic [AXI_ADDR_WIDTH-1:0] reg_addr(input logic [5:0] idx);
        return BASE_ADDR + (AXI_ADDR_WIDTH'(idx) << 3);
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        poll_d  = poll_q;
        ct_d    = ct_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (job_valid_i) begin
                    state_d = S_WR_KSEL;
                    k_d     = '0;
                    ct_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_WR_KSEL: state_d = S_WR_STATE;
            S_WR_STATE: begin
                if (k_q == 2'd3) begin
                    state_d = S_WR_PT;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_WR_PT: begin
                if (k_q == 2'd3) begin
                    state_d = S_START_HI;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_START_HI: state_d = S_START_LO;
            S_START_LO: begin
                state_d = S_POLL;
                poll_d  = '0;
            end
            S_POLL: begin
                // A ready flag on the final allowed poll still wins over the timeout.
                if (bus_rdata_i[0]) begin
                    state_d = S_RD_CT;
                    k_d     = '0;
                    poll_d  = '0;
                end else if (poll_q == POLL_LAST) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    ct_d    = '0;
                    poll_d  = '0;
                end else begin
                    poll_d = poll_q + PCW'(1);
                end
            end
            S_RD_CT: begin
                ct_d[32*k_q +: 32] = bus_rdata_i[31:0];
                if (k_q == 2'd3) begin
                    state_d = S_RESP;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_RESP: begin
                if (res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are registered, so decode the access of the state being
        // entered. WR_KSEL is only entered from the accept cycle, so its data
        // comes straight from the job port.
        en_d   = 1'b0;
        we_d   = 1'b0;
        idx_d  = '0;
        data_d = '0;
        case (state_d)
            S_WR_KSEL: begin
                en_d = 1'b1; we_d = 1'b1; idx_d = IDX_KSEL;
                data_d = {30'b0, job_key_sel_i};
            end
            S_WR_STATE: begin
                en_d = 1'b1; we_d = 1'b1; idx_d = IDX_STATE + {4'b0, k_d};
                data_d = st_q[32*k_d +: 32];
            end
            S_WR_PT: begin
                en_d = 1'b1; we_d = 1'b1; idx_d = IDX_PC + {4'b0, k_d};
                data_d = pt_q[32*k_d +: 32];
            end
            S_START_HI: begin
                en_d = 1'b1; we_d = 1'b1; idx_d = IDX_START; data_d = 32'd1;
            end
            S_START_LO: begin
                en_d = 1'b1; we_d = 1'b1; idx_d = IDX_START; data_d = 32'd0;
            end
            S_POLL:  begin en_d = 1'b1; idx_d = IDX_CTV; end
            S_RD_CT: begin en_d = 1'b1; idx_d = IDX_CT + {4'b0, k_d}; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            poll_q      <= '0;
            st_q        <= '0;
            pt_q        <= '0;
            ct_q        <= '0;
            err_q       <= 1'b0;
            bus_en_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            poll_q  <= poll_d;
            ct_q    <= ct_d;
            err_q   <= err_d;
            if (state_q == S_IDLE && job_valid_i) begin
                st_q <= job_state_i;
                pt_q <= job_pt_i;
            end
            bus_en_q    <= en_d;
            bus_we_q    <= we_d;
            bus_addr_q  <= en_d ? reg_addr(idx_d) : '0;
            bus_wdata_q <= data_d;
        end
    end

    assign job_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign res_valid_o = (state_q == S_RESP);
    assign res_ct_o    = ct_q;
    assign res_err_o   = err_q;
    assign bus_en_o    = bus_en_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = {32'b0, bus_wdata_q};

endmodule

// File: tb/tb_aes_job_master.sv
// -----------------------------------------------------------------------------
// tb_aes_job_master
//
// Directed and randomized bench for aes_job_master. A small peripheral model
// keeps a register file written by the DUT. It raises ct_valid on a chosen
// poll and returns a keyed mix of the programmed state and plaintext. The
// expected ciphertext is derived directly from the job fields. The expected
// access trace is derived from the register-map rules.
// -----------------------------------------------------------------------------
module tb_aes_job_master;

    localparam int unsigned T    = 8;
    localparam logic [63:0] BASE = 64'h0000_0000_4000_0000;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         job_valid_i;
    logic         job_ready_o;
    logic [1:0]   job_key_sel_i;
    logic [127:0] job_state_i;
    logic [127:0] job_pt_i;
    logic         res_valid_o;
    logic         res_ready_i;
    logic [127:0] res_ct_o;
    logic         res_err_o;
    logic         busy_o;
    logic         bus_en_o;
    logic         bus_we_o;
    logic [63:0]  bus_addr_o;
    logic [63:0]  bus_wdata_o;
    logic [63:0]  bus_rdata_i;

    aes_job_master #(.AXI_ADDR_WIDTH(64), .BASE_ADDR(BASE), .POLL_TIMEOUT(T)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_key_sel_i(job_key_sel_i), .job_state_i(job_state_i), .job_pt_i(job_pt_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_ct_o(res_ct_o), .res_err_o(res_err_o), .busy_o(busy_o),
        .bus_en_o(bus_en_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_c  = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- peripheral model ----------------
    logic [31:0] regs [0:63];
    int          poll_cnt    = 0;
    int          poll_target = 0;   // 0: ct_valid never rises
    logic [63:0] a_off;
    int          p_idx;
    logic        ctv;

    assign a_off = bus_addr_o - BASE;
    assign p_idx = int'(a_off[8:3]);
    assign ctv   = (poll_target != 0) && (poll_cnt + 1 >= poll_target);

    function automatic logic [31:0] swap16(input logic [31:0] w);
        return {w[15:0], w[31:16]};
    endfunction

    function automatic logic [31:0] key_word(input logic [31:0] s);
        if (s == 32'd0) return 32'h1357_9BDF;
        if (s == 32'd1) return 32'h2468_ACE0;
        return 32'hC0DE_F00D;
    endfunction

    always @(posedge clk_i) begin
        if (bus_en_o && a_off < 64'd512) begin
            if (bus_we_o) begin
                regs[p_idx] <= bus_wdata_o[31:0];
                if (p_idx == 0 && bus_wdata_o[0]) poll_cnt <= 0;
            end else if (p_idx == 11) begin
                poll_cnt <= poll_cnt + 1;
            end
        end
    end

    always_comb begin
        bus_rdata_i = 64'h0;
        if (bus_en_o && !bus_we_o && a_off < 64'd512) begin
            if (p_idx == 11)
                bus_rdata_i = 64'hF0F0_F0F0_F0F0_F0F0 | {63'b0, ctv};
            else if (p_idx >= 12 && p_idx <= 15)
                bus_rdata_i = {32'hA5A5_A5A5, regs[p_idx-11] ^ swap16(regs[p_idx+4])
                               ^ key_word(regs[32]) ^ 32'(p_idx - 12)};
        end
    end

    // ---------------- access monitor ----------------
    logic [63:0] mon_addr [$];
    logic [63:0] mon_wdata[$];
    logic        mon_we   [$];
    int          mon_cyc  [$];

    always @(negedge clk_i) begin
        if (bus_en_o) begin
            mon_addr.push_back(bus_addr_o);
            mon_wdata.push_back(bus_wdata_o);
            mon_we.push_back(bus_we_o);
            mon_cyc.push_back(cyc);
        end
    end

    // ---------------- reference and helpers ----------------
    function automatic logic [127:0] ref_ct(input logic [1:0] ks, input logic [127:0] st,
                                            input logic [127:0] pt);
        logic [127:0] r;
        for (int k = 0; k < 4; k++)
            r[32*k +: 32] = pt[32*k +: 32] ^ swap16(st[32*k +: 32]) ^ key_word(32'(ks)) ^ 32'(k);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        mon_addr.delete(); mon_wdata.delete(); mon_we.delete(); mon_cyc.delete();
    endtask

    task automatic check_reset_values(input string p);
        chk({p, "_job_ready"}, job_ready_o, 1);
        chk({p, "_res_valid"}, res_valid_o, 0);
        chk({p, "_res_ct"},    res_ct_o,    0);
        chk({p, "_res_err"},   res_err_o,   0);
        chk({p, "_busy"},      busy_o,      0);
        chk({p, "_bus_en"},    bus_en_o,    0);
        chk({p, "_bus_we"},    bus_we_o,    0);
        chk({p, "_bus_addr"},  bus_addr_o,  0);
        chk({p, "_bus_wdata"}, bus_wdata_o, 0);
    endtask

    task automatic check_log(input logic [1:0] ks, input logic [127:0] st, input logic [127:0] pt,
                             input int n_poll, input bit rd);
        logic        e_we [$];
        int          e_idx[$];
        logic [63:0] e_d  [$];
        int          n;
        e_we.push_back(1); e_idx.push_back(32); e_d.push_back({62'b0, ks});
        for (int k = 0; k < 4; k++) begin
            e_we.push_back(1); e_idx.push_back(16 + k); e_d.push_back({32'b0, st[32*k +: 32]});
        end
        for (int k = 0; k < 4; k++) begin
            e_we.push_back(1); e_idx.push_back(1 + k); e_d.push_back({32'b0, pt[32*k +: 32]});
        end
        e_we.push_back(1); e_idx.push_back(0); e_d.push_back(64'd1);
        e_we.push_back(1); e_idx.push_back(0); e_d.push_back(64'd0);
        for (int i = 0; i < n_poll; i++) begin
            e_we.push_back(0); e_idx.push_back(11); e_d.push_back(64'd0);
        end
        if (rd) for (int k = 0; k < 4; k++) begin
            e_we.push_back(0); e_idx.push_back(12 + k); e_d.push_back(64'd0);
        end
        chk("log_len", mon_we.size(), e_we.size());
        n = (mon_we.size() < e_we.size()) ? mon_we.size() : e_we.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("log_addr[%0d]", i), mon_addr[i], BASE + 64'(e_idx[i]) * 64'd8);
            chk($sformatf("log_we[%0d]", i), mon_we[i], e_we[i]);
            if (e_we[i]) chk($sformatf("log_wdata[%0d]", i), mon_wdata[i], e_d[i]);
            chk($sformatf("log_cycle[%0d]", i), mon_cyc[i], acc_c + 1 + i);
        end
        clear_log();
    endtask

    task automatic start_job(input logic [1:0] ks, input logic [127:0] st, input logic [127:0] pt,
                             input int tgt, input int hold);
        tick();
        chk("idle_ready", job_ready_o, 1);
        chk("idle_busy", busy_o, 0);
        res_ready_i   = (hold == 0);
        poll_target   = tgt;
        job_key_sel_i = ks;
        job_state_i   = st;
        job_pt_i      = pt;
        job_valid_i   = 1'b1;
        acc_c         = cyc;
        tick();
        job_valid_i = 1'b0;
        chk("acc_busy", busy_o, 1);
        chk("acc_ready", job_ready_o, 0);
        chk("acc_err_clr", res_err_o, 0);
    endtask

    task automatic finish_job(input logic [1:0] ks, input logic [127:0] st, input logic [127:0] pt,
                              input int tgt, input int hold);
        bit           got = 0;
        bit           exp_err;
        logic [127:0] held;
        exp_err = (tgt == 0) || (tgt > int'(T));
        // Garbage on the job port while busy must be ignored.
        for (int n = 0; n < 400; n++) begin
            if (res_valid_o) begin
                got = 1;
                break;
            end
            job_valid_i   = 1'($urandom);
            job_key_sel_i = 2'($urandom);
            job_state_i   = rand128();
            job_pt_i      = rand128();
            tick();
        end
        job_valid_i = 1'b0;
        chk("res_seen", got, 1);
        chk("latency", cyc - acc_c, exp_err ? 12 + int'(T) : 16 + tgt);
        chk("res_err", res_err_o, exp_err);
        chk("res_ct", res_ct_o, exp_err ? 128'd0 : ref_ct(ks, st, pt));
        held = res_ct_o;
        for (int i = 0; i < hold; i++) begin
            job_valid_i = 1'($urandom);
            tick();
            chk("hold_valid", res_valid_o, 1);
            chk("hold_ct", res_ct_o, held);
            chk("hold_no_bus", bus_en_o, 0);
            chk("hold_not_ready", job_ready_o, 0);
        end
        if (hold > 0) begin
            job_valid_i = 1'b0;
            res_ready_i = 1'b1;
            tick();
            chk("rel_valid", res_valid_o, 0);
            chk("rel_ready", job_ready_o, 1);
        end
        check_log(ks, st, pt, exp_err ? int'(T) : tgt, !exp_err);
    endtask

    task automatic run_job(input logic [1:0] ks, input logic [127:0] st, input logic [127:0] pt,
                           input int tgt, input int hold);
        start_job(ks, st, pt, tgt, hold);
        finish_job(ks, st, pt, tgt, hold);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] s, p;
        rst_ni        = 1'b0;
        job_valid_i   = 1'b0;
        job_key_sel_i = '0;
        job_state_i   = '0;
        job_pt_i      = '0;
        res_ready_i   = 1'b0;
        tick();
        tick();
        check_reset_values("por");
        rst_ni = 1'b1;
        clear_log();

        run_job(2'd1, 128'd0, 128'h00112233_44556677_8899aabb_ccddeeff, 3, 0);
        run_job(2'd2, rand128(), rand128(), 0, 5);
        chk("err_held_idle", res_err_o, 1);
        run_job(2'd0, rand128(), rand128(), 2, 5);
        run_job(2'd3, rand128(), rand128(), int'(T), 0);
        run_job(2'd0, rand128(), rand128(), 1, 0);
        run_job(2'd1, rand128(), rand128(), 9, 0);

        for (int j = 0; j < 6; j++)
            run_job(2'($urandom), rand128(), rand128(), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 2)));

        s = rand128();
        p = rand128();
        start_job(2'd2, s, p, 0, 0);
        for (int n = 0; n < 20 && cyc < acc_c + 14; n++) tick();
        chk("pre_rst_polling", bus_en_o && !bus_we_o, 1);
        clear_log();
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_values("rst_async");
        tick();
        tick();
        rst_ni = 1'b1;
        chk("rst_no_access", mon_we.size(), 0);
        clear_log();
        run_job(2'd1, rand128(), rand128(), 4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_job_master.md
# aes_job_master

Register-bus initiator that drives one AES-192 peripheral through its word-indexed register map, so a hardware client can encrypt without software involvement. It accepts a job (key select, state, plaintext) on a valid/ready port, writes the peripheral's registers, pulses start, polls `ct_valid`, reads back the 128-bit ciphertext and returns it on a result valid/ready port. It sits between an accelerator client and the `en/we/address/wdata/rdata` side of the AES peripheral's AXI-lite front end.

## Interface
- `AXI_ADDR_WIDTH`, 64, width of `bus_addr_o`.
- `BASE_ADDR`, 0, peripheral base address; register index `i` is at `BASE_ADDR + (i << 3)`.
- `POLL_TIMEOUT`, 1024, maximum poll reads of `ct_valid` before an error is reported (≥1).
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `job_valid_i` in 1: job offered.
- `job_ready_o` out 1: job accepted when both are high.
- `job_key_sel_i` in 2: key slot (0 → key0, 1 → key1, 2/3 → key2).
- `job_state_i` in 128: AES state word.
- `job_pt_i` in 128: plaintext.
- `res_valid_o` out 1: result available.
- `res_ready_i` in 1: result consumed when both are high.
- `res_ct_o` out 128: ciphertext.
- `res_err_o` out 1: poll timed out; `res_ct_o` is 0.
- `busy_o` out 1: FSM is not in IDLE.
- `bus_en_o` out 1: access strobe, one access per cycle.
- `bus_we_o` out 1: 1 = write, 0 = read.
- `bus_addr_o` out AXI_ADDR_WIDTH: access address.
- `bus_wdata_o` out 64: write data; bits [63:32] are always 0.
- `bus_rdata_i` in 64: read data, combinational, sampled in the same cycle as a read strobe.

## Operation
- Register indices used:
  - 0 start
  - 1–4 p_c[3..0]
  - 11 ct_valid
  - 12–15 ct words
  - 16–19 state[3..0]
  - 32 key_sel
- Keys are never written; they are provisioned separately.
- Job inputs are captured into internal registers on the accept handshake. Inputs are ignored at all other times.
- FSM states, one bus access per state-cycle:
  - IDLE: `job_ready_o`=1, no access. Accept → WR_KSEL.
  - WR_KSEL: write idx 32, data = `{62'b0, key_sel}`.
  - WR_STATE ×4, word counter k=0..3: write idx 16+k, data = state[32k+31:32k].
  - WR_PT ×4: write idx 1+k, data = pt[32k+31:32k].
  - START_HI: write idx 0, data 1.
  - START_LO: write idx 0, data 0.
  - POLL: read idx 11 each cycle.
    - `bus_rdata_i[0]`=1 → RD_CT, poll counter cleared.
    - Otherwise the counter increments. When it reaches POLL_TIMEOUT → RESP with err=1 and ct=0.
  - RD_CT ×4: read idx 12+k; ct[32k+31:32k] ← `bus_rdata_i[31:0]`.
  - RESP: `res_valid_o`=1, held with stable data until `res_ready_i`. Then → IDLE.
- The peripheral clears `ct_valid` on the start rising edge, so the first POLL read cannot see a stale result.
- `res_err_o` is cleared on the next job accept.
- Reset mid-operation aborts the job with no further bus access. A half-written register map is left as is; the next job rewrites every register it uses.

## Timing
- Reset values:
  - `job_ready_o`=1
  - `res_valid_o`=0
  - `res_ct_o`=0
  - `res_err_o`=0
  - `busy_o`=0
  - `bus_en_o`=0, `bus_we_o`=0, `bus_addr_o`=0, `bus_wdata_o`=0
- All bus outputs are registered. `bus_en_o` is high exactly in WR_*, START_*, POLL and RD_CT cycles and low in IDLE and RESP.
- Accept at edge N: first write is driven in cycle N+1. The 11 writes occupy N+1..N+11, and the first POLL is in N+12.
- If ct_valid is seen on the p-th poll (p≥1): reads occupy N+12+p..N+15+p, and `res_valid_o` rises in cycle N+16+p. If `res_ready_i` is already high, return to IDLE at N+17+p.
- Timeout: exactly POLL_TIMEOUT poll reads, then RESP in the following cycle.
- Back-to-back: `job_ready_o` is high in the cycle after the RESP handshake, not during RESP.

## Test plan
- Single job, key_sel=1, state=0, pt=`128'h00112233_44556677_8899aabb_ccddeeff`, model core asserts ct_valid 3 polls after start → exactly 11 writes in the order and with the data above (idx4 data `32'h00112233`), 3 polls, 4 reads, `res_ct_o` equals the model ct, `res_err_o`=0, total latency accept→`res_valid_o` = 19 cycles.
- Model never asserts ct_valid, POLL_TIMEOUT=8 → exactly 8 reads of idx 11, then `res_valid_o`=1, `res_err_o`=1, `res_ct_o`=0. The next job clears `res_err_o`.
- RESP backpressure: `res_ready_i` low for 5 cycles → `res_valid_o` and `res_ct_o` stable, no bus access, `job_ready_o`=0 throughout.
- `job_valid_i` toggling and input changes while busy → ignored. The second job starts only after RESP, and its first write carries the new key_sel.
- `rst_ni` asserted during POLL, asynchronously mid-cycle → all outputs at reset values immediately. After release, a fresh job completes correctly.
- Back-to-back jobs with `res_ready_i`=1 → IDLE for exactly one cycle between jobs, correct ct for each.
